// File: rtl/noc_resp_deframer_if.sv
// Stream input plus header/payload valid-ready channels of the NoC response deframer.
// master = deframer side, slave = stream source / consumer side.
interface noc_resp_deframer_if #(
  parameter int LW = 5
);
  logic          noc_from_dev_ctl;
  logic [7:0]    noc_from_dev_data;
  logic          hdr_valid;
  logic          hdr_ready;
  logic [7:0]    hdr_cmd;
  logic [LW-1:0] hdr_len;
  logic          hdr_err;
  logic          pl_valid;
  logic          pl_ready;
  logic [7:0]    pl_data;
  logic          pl_last;

  modport master (
    input  noc_from_dev_ctl, noc_from_dev_data, hdr_ready, pl_ready,
    output hdr_valid, hdr_cmd, hdr_len, hdr_err, pl_valid, pl_data, pl_last
  );

  modport slave (
    output noc_from_dev_ctl, noc_from_dev_data, hdr_ready, pl_ready,
    input  hdr_valid, hdr_cmd, hdr_len, hdr_err, pl_valid, pl_data, pl_last
  );
endinterface

// File: rtl/noc_resp_deframer.sv
// Parses the switch response stream into packets, buffers whole packets and exposes them on header/payload channels.
// Optional NOC_RESP_DEFRAMER_STATS_EN adds saturating commit/drop counters.
module noc_resp_deframer #(
  parameter int MAX_LEN   = 16,
  parameter int BUF_DEPTH = 64,
  parameter int HDR_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  noc_resp_deframer_if.master bus
`ifdef NOC_RESP_DEFRAMER_STATS_EN
  ,
  output logic [15:0]         stat_pkt_cnt,
  output logic [15:0]         stat_drop_cnt
`endif
);
  localparam int LW  = $clog2(MAX_LEN + 1);
  localparam int AW  = $clog2(BUF_DEPTH);
  localparam int PW  = AW + 1;
  localparam int HAW = $clog2(HDR_DEPTH);
  localparam int HPW = HAW + 1;
  localparam logic [PW-1:0]  USED_LIM = PW'(BUF_DEPTH - MAX_LEN);
  localparam logic [HPW:0]   HDR_LIM  = (HPW + 1)'(HDR_DEPTH);
  localparam logic [LW-1:0]  LEN_MAX  = LW'(MAX_LEN);

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DROP = 2'd2} state_t;

  state_t         state_r, state_nxt_s;
  logic [7:0]     cmd_r;
  logic [LW-1:0]  len_r;
  logic           err_r;
  logic [PW-1:0]  wr_ptr_r, commit_ptr_r, rd_ptr_r, used_s;
  logic [HPW-1:0] hdr_wr_r, hdr_rd_r, hdr_cnt_s;

  logic [7:0]     buf_data_r [BUF_DEPTH];
  logic           buf_last_r [BUF_DEPTH];
  logic [7:0]     hdr_cmd_mem_r [HDR_DEPTH];
  logic [LW-1:0]  hdr_len_mem_r [HDR_DEPTH];
  logic           hdr_err_mem_r [HDR_DEPTH];

  logic is_cmd_s, is_nop_s, is_dat_s;
  logic commit_s, wr_en_s, trunc_s, start_s, load_s, drop_s;
  logic buf_room_s, hdr_room_s;
  logic pl_valid_s, hdr_valid_s, pl_pop_s, hdr_pop_s;
  logic [AW-1:0] last_idx_s;

  assign is_cmd_s    = bus.noc_from_dev_ctl && (bus.noc_from_dev_data != 8'h00);
  assign is_nop_s    = bus.noc_from_dev_ctl && (bus.noc_from_dev_data == 8'h00);
  assign is_dat_s    = !bus.noc_from_dev_ctl;
  assign used_s      = wr_ptr_r - rd_ptr_r;
  assign hdr_cnt_s   = hdr_wr_r - hdr_rd_r;
  assign buf_room_s  = (used_s <= USED_LIM);
  assign last_idx_s  = wr_ptr_r[AW-1:0] - AW'(1);
  assign pl_valid_s  = (rd_ptr_r != commit_ptr_r);
  assign hdr_valid_s = (hdr_wr_r != hdr_rd_r);
  assign pl_pop_s    = pl_valid_s && bus.pl_ready;
  assign hdr_pop_s   = hdr_valid_s && bus.hdr_ready;

  // Outputs are forced to zero whenever nothing is presented, which also covers reset.
  assign bus.pl_valid  = pl_valid_s;
  assign bus.pl_data   = pl_valid_s ? buf_data_r[rd_ptr_r[AW-1:0]] : 8'h00;
  assign bus.pl_last   = pl_valid_s ? buf_last_r[rd_ptr_r[AW-1:0]] : 1'b0;
  assign bus.hdr_valid = hdr_valid_s;
  assign bus.hdr_cmd   = hdr_valid_s ? hdr_cmd_mem_r[hdr_rd_r[HAW-1:0]] : 8'h00;
  assign bus.hdr_len   = hdr_valid_s ? hdr_len_mem_r[hdr_rd_r[HAW-1:0]] : {LW{1'b0}};
  assign bus.hdr_err   = hdr_valid_s ? hdr_err_mem_r[hdr_rd_r[HAW-1:0]] : 1'b0;

  // Next-state and datapath strobes; a CMD seen in RECV commits and re-admits in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    commit_s    = 1'b0;
    wr_en_s     = 1'b0;
    trunc_s     = 1'b0;
    start_s     = 1'b0;
    load_s      = 1'b0;
    drop_s      = 1'b0;
    hdr_room_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (is_cmd_s) start_s = 1'b1;
        else          start_s = 1'b0;
      end
      RECV: begin
        if (is_dat_s) begin
          if (len_r < LEN_MAX) wr_en_s = 1'b1;
          else                 trunc_s = 1'b1;
        end else if (is_nop_s) begin
          commit_s    = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          commit_s = 1'b1;
          start_s  = 1'b1;
        end
      end
      DROP: begin
        if (is_nop_s)      state_nxt_s = IDLE;
        else if (is_cmd_s) start_s     = 1'b1;
        else               state_nxt_s = DROP;
      end
      default: state_nxt_s = IDLE;
    endcase
    // A header pushed this cycle occupies a slot; a same-cycle pop is not credited.
    hdr_room_s = (({1'b0, hdr_cnt_s} + {{HPW{1'b0}}, commit_s}) < HDR_LIM);
    if (start_s) begin
      if (buf_room_s && hdr_room_s) begin
        load_s      = 1'b1;
        state_nxt_s = RECV;
      end else begin
        drop_s      = 1'b1;
        state_nxt_s = DROP;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // FSM state, packet accumulator and all buffer/FIFO pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      cmd_r        <= 8'h00;
      len_r        <= {LW{1'b0}};
      err_r        <= 1'b0;
      wr_ptr_r     <= {PW{1'b0}};
      commit_ptr_r <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      hdr_wr_r     <= {HPW{1'b0}};
      hdr_rd_r     <= {HPW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (load_s) begin
        cmd_r <= bus.noc_from_dev_data;
        len_r <= {LW{1'b0}};
        err_r <= 1'b0;
      end else if (wr_en_s) begin
        len_r <= len_r + LW'(1);
      end else if (trunc_s) begin
        err_r <= 1'b1;
      end
      if (wr_en_s)   wr_ptr_r     <= wr_ptr_r + PW'(1);
      if (commit_s)  commit_ptr_r <= wr_ptr_r;
      if (commit_s)  hdr_wr_r     <= hdr_wr_r + HPW'(1);
      if (pl_pop_s)  rd_ptr_r     <= rd_ptr_r + PW'(1);
      if (hdr_pop_s) hdr_rd_r     <= hdr_rd_r + HPW'(1);
    end
  end

  // Storage arrays; contents are only observable through the valid-gated read ports.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      buf_data_r[wr_ptr_r[AW-1:0]] <= bus.noc_from_dev_data;
      buf_last_r[wr_ptr_r[AW-1:0]] <= 1'b0;
    end
    if (commit_s && (len_r != {LW{1'b0}})) buf_last_r[last_idx_s] <= 1'b1;
    if (commit_s) begin
      hdr_cmd_mem_r[hdr_wr_r[HAW-1:0]] <= cmd_r;
      hdr_len_mem_r[hdr_wr_r[HAW-1:0]] <= len_r;
      hdr_err_mem_r[hdr_wr_r[HAW-1:0]] <= err_r;
    end
  end

`ifdef NOC_RESP_DEFRAMER_STATS_EN
  // Saturating packet and drop counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_pkt_cnt  <= 16'h0000;
      stat_drop_cnt <= 16'h0000;
    end else begin
      if (commit_s && (stat_pkt_cnt != 16'hFFFF))  stat_pkt_cnt  <= stat_pkt_cnt + 16'h0001;
      if (drop_s && (stat_drop_cnt != 16'hFFFF))   stat_drop_cnt <= stat_drop_cnt + 16'h0001;
    end
  end
`endif
endmodule

// File: tb/tb_noc_resp_deframer.sv
// Directed bench for noc_resp_deframer; stat counters are checked when NOC_RESP_DEFRAMER_STATS_EN is defined.
module tb_noc_resp_deframer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  noc_resp_deframer_if #(.LW(5)) bus ();
`ifdef NOC_RESP_DEFRAMER_STATS_EN
  logic [15:0] stat_pkt_cnt, stat_drop_cnt;
`endif

  noc_resp_deframer #(.MAX_LEN(16), .BUF_DEPTH(64), .HDR_DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef NOC_RESP_DEFRAMER_STATS_EN
    ,
    .stat_pkt_cnt  (stat_pkt_cnt),
    .stat_drop_cnt (stat_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one stream byte; returns at the negedge after it was sampled.
  task automatic send(input logic c, input logic [7:0] d);
    bus.noc_from_dev_ctl  = c;
    bus.noc_from_dev_data = d;
    @(negedge clk);
    bus.noc_from_dev_ctl  = 1'b1;
    bus.noc_from_dev_data = 8'h00;
  endtask

  task automatic chk_hdr(input string tag, input logic [7:0] c, input logic [4:0] l, input logic e);
    chk({tag, "_hv"}, 32'(bus.hdr_valid), 32'd1);
    chk({tag, "_cmd"}, 32'(bus.hdr_cmd), 32'(c));
    chk({tag, "_len"}, 32'(bus.hdr_len), 32'(l));
    chk({tag, "_err"}, 32'(bus.hdr_err), 32'(e));
  endtask

  task automatic chk_pl(input string tag, input logic [7:0] d, input logic l);
    chk({tag, "_pv"}, 32'(bus.pl_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.pl_data), 32'(d));
    chk({tag, "_last"}, 32'(bus.pl_last), 32'(l));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hv"}, 32'(bus.hdr_valid), 32'd0);
    chk({tag, "_pv"}, 32'(bus.pl_valid), 32'd0);
    chk({tag, "_cmd"}, 32'(bus.hdr_cmd), 32'd0);
    chk({tag, "_len"}, 32'(bus.hdr_len), 32'd0);
    chk({tag, "_err"}, 32'(bus.hdr_err), 32'd0);
    chk({tag, "_data"}, 32'(bus.pl_data), 32'd0);
    chk({tag, "_last"}, 32'(bus.pl_last), 32'd0);
  endtask

  initial begin
    bus.noc_from_dev_ctl  = 1'b1;
    bus.noc_from_dev_data = 8'h00;
    bus.hdr_ready         = 1'b0;
    bus.pl_ready          = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("rst0");
    reset_n = 1'b1;
    @(negedge clk);

    // Basic packet with readies high; nothing visible before the NOP is sampled.
    bus.hdr_ready = 1'b1;
    bus.pl_ready  = 1'b1;
    send(1'b1, 8'h23);
    chk("t2_pv_cmd", 32'(bus.pl_valid), 32'd0);
    send(1'b0, 8'hA1);
    chk("t2_pv_a1", 32'(bus.pl_valid), 32'd0);
    send(1'b0, 8'hA2);
    chk("t2_pv_a2", 32'(bus.pl_valid), 32'd0);
    send(1'b0, 8'hA3);
    chk("t2_pv_a3", 32'(bus.pl_valid), 32'd0);
    chk("t2_hv_a3", 32'(bus.hdr_valid), 32'd0);
    send(1'b1, 8'h00);
    chk_hdr("t1_hdr", 8'h23, 5'd3, 1'b0);
    chk_pl("t1_a1", 8'hA1, 1'b0);
    @(negedge clk);
    chk("t1_hv_pop", 32'(bus.hdr_valid), 32'd0);
    chk_pl("t1_a2", 8'hA2, 1'b0);
    @(negedge clk);
    chk_pl("t1_a3", 8'hA3, 1'b1);
    @(negedge clk);
    chk("t1_pv_end", 32'(bus.pl_valid), 32'd0);

    // Truncation: 18 bytes into a 16-byte limit.
    bus.hdr_ready = 1'b0;
    bus.pl_ready  = 1'b0;
    send(1'b1, 8'h31);
    for (int i = 0; i < 18; i++) send(1'b0, 8'(i));
    send(1'b1, 8'h00);
    chk_hdr("t3_hdr", 8'h31, 5'd16, 1'b1);
    bus.hdr_ready = 1'b1;
    bus.pl_ready  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk_pl("t3_pl", 8'(i), (i == 15));
      @(negedge clk);
    end
    chk("t3_pv_end", 32'(bus.pl_valid), 32'd0);
    chk("t3_hv_end", 32'(bus.hdr_valid), 32'd0);

    // Header FIFO full: fifth packet is dropped.
    bus.hdr_ready = 1'b0;
    bus.pl_ready  = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send(1'b1, 8'(k));
      send(1'b0, 8'hB0 + 8'(k));
      send(1'b1, 8'h00);
    end
`ifdef NOC_RESP_DEFRAMER_STATS_EN
    chk("t4_drop_cnt", 32'(stat_drop_cnt), 32'd1);
`endif
    bus.hdr_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk_hdr("t4_hdr", 8'(k), 5'd1, 1'b0);
      @(negedge clk);
    end
    chk("t4_hv_end", 32'(bus.hdr_valid), 32'd0);
    bus.pl_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk_pl("t4_pl", 8'hB0 + 8'(k), 1'b1);
      @(negedge clk);
    end
    chk("t4_pv_end", 32'(bus.pl_valid), 32'd0);

    // Back-to-back packets with no NOP between them.
    bus.hdr_ready = 1'b0;
    bus.pl_ready  = 1'b0;
    send(1'b1, 8'h11);
    send(1'b0, 8'hAA);
    send(1'b1, 8'h22);
    send(1'b0, 8'hBB);
    send(1'b1, 8'h00);
    bus.hdr_ready = 1'b1;
    chk_hdr("t5_hdr1", 8'h11, 5'd1, 1'b0);
    @(negedge clk);
    chk_hdr("t5_hdr2", 8'h22, 5'd1, 1'b0);
    @(negedge clk);
    chk("t5_hv_end", 32'(bus.hdr_valid), 32'd0);
    bus.pl_ready = 1'b1;
    chk_pl("t5_aa", 8'hAA, 1'b1);
    @(negedge clk);
    chk_pl("t5_bb", 8'hBB, 1'b1);
    @(negedge clk);
    chk("t5_pv_end", 32'(bus.pl_valid), 32'd0);

    // Reset mid-packet with a committed, unread packet still buffered.
    bus.hdr_ready = 1'b0;
    bus.pl_ready  = 1'b0;
    send(1'b1, 8'h77);
    send(1'b0, 8'h99);
    send(1'b1, 8'h00);
    chk_hdr("t6_pre", 8'h77, 5'd1, 1'b0);
    send(1'b1, 8'h44);
    send(1'b0, 8'h01);
    send(1'b0, 8'h02);
    reset_n = 1'b0;
    #1;
    chk_zero("t6_rst");
    repeat (2) @(negedge clk);
    chk_zero("t6_rst_hold");
    reset_n = 1'b1;
    send(1'b0, 8'h55);
    chk("t6_pv_dat", 32'(bus.pl_valid), 32'd0);
    send(1'b1, 8'h66);
    send(1'b1, 8'h00);
    chk_hdr("t6_hdr", 8'h66, 5'd0, 1'b0);
    chk("t6_pv", 32'(bus.pl_valid), 32'd0);
`ifdef NOC_RESP_DEFRAMER_STATS_EN
    chk("t6_pkt_cnt", 32'(stat_pkt_cnt), 32'd1);
    chk("t6_drop_cnt", 32'(stat_drop_cnt), 32'd0);
`endif
    bus.hdr_ready = 1'b1;
    @(negedge clk);
    chk("t6_hv_end", 32'(bus.hdr_valid), 32'd0);
    chk("t6_pv_end", 32'(bus.pl_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
